branch_sequencer: RTL and testbench

- Program-counter sequencer for the 8-bit pipelined core.
- Resolves br / brz / brn / br.sub / return from the execute-stage instruction word.
- Keeps a multi-entry return-address stack, replacing the single link register.
- Drives the fetch PC and pipeline flush, and holds in a FAULT state on stack misuse.

---
 rtl/branch_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_branch_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// branch_sequencer: fetch-PC sequencer with a return-address stack for the 8-bit core.
// Build option RAS_WRAP_EN: a full stack overwrites its oldest entry instead of faulting.
module branch_sequencer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [7:0]  RESET_PC     = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    instr_valid,
  input  logic [23:0]             instruction,
  input  logic                    Z,
  input  logic                    N,
  output logic [7:0]              pc,
  output logic                    flush,
  output logic                    redirect,
  output logic [$clog2(DEPTH):0]  sp,
  output logic                    fault,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam int CW = 2;

  localparam logic [AW-1:0] IONE     = AW'(1);
  localparam logic [SW-1:0] SP_FULL  = SW'(DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  localparam logic [3:0] OP_BR  = 4'b1001;
  localparam logic [3:0] OP_BC  = 4'b1010;
  localparam logic [3:0] OP_CAL = 4'b1011;
  localparam logic [3:0] OP_RET = 4'b1100;

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            redir_q, redir_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sp_q, sp_d;
  logic [AW-1:0]   base_q, base_d;
  logic            fault_q, fault_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [7:0]      stk_q [DEPTH];

  logic [3:0]      op;
  logic            is_jmp;
  logic            is_call;
  logic            is_ret;
  logic            full;
  logic            empty;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic [7:0]      wr_data;
  logic            push_en;
  logic            take;
  logic            trap;
  logic [7:0]      tgt;
  logic            unused_bits;

  assign op      = instruction[15:12];
  assign is_jmp  = (op == OP_BR)
                 | ((op == OP_BC) & (instruction[11] ? N : Z));
  assign is_call = (op == OP_CAL);
  assign is_ret  = (op == OP_RET);
  assign full    = (sp_q == SP_FULL);
  assign empty   = (sp_q == '0);
  assign wr_idx  = base_q + sp_q[AW-1:0];
  assign rd_idx  = base_q + sp_q[AW-1:0] - IONE;
  assign wr_data = instruction[23:16] + 8'd2;

  assign unused_bits = ^instruction[10:8];

  // Next-state: decode live ops, sequence flush, trap on stack misuse
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    redir_d = 1'b0;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    base_d  = base_q;
    fault_d = fault_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    take    = 1'b0;
    trap    = 1'b0;
    tgt     = instruction[7:0];
    if (!stall) begin
      unique case (state_q)
        S_RUN: begin
          pc_d = pc_q + 8'd2;
          if (instr_valid) begin
            unique case (1'b1)
              is_jmp: take = 1'b1;
              is_call: begin
                if (!full) begin
                  push_en = 1'b1;
                  sp_d    = sp_q + SW'(1);
                  take    = 1'b1;
                end else begin
                  ovf_d = 1'b1;
`ifdef RAS_WRAP_EN
                  push_en = 1'b1;
                  base_d  = base_q + IONE;
                  take    = 1'b1;
`else
                  trap = 1'b1;
`endif
                end
              end
              is_ret: begin
                if (!empty) begin
                  tgt  = stk_q[rd_idx];
                  sp_d = sp_q - SW'(1);
                  take = 1'b1;
                end else begin
                  unf_d = 1'b1;
                  trap  = 1'b1;
                end
              end
              default: ;
            endcase
          end
          if (trap) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
            flush_d = 1'b1;
            pc_d    = pc_q;
          end else if (take) begin
            pc_d    = tgt;
            redir_d = 1'b1;
            flush_d = 1'b1;
            state_d = S_FLUSH;
            cnt_d   = CNT_INIT;
          end
        end
        S_FLUSH: begin
          pc_d = pc_q + 8'd2;
          if (cnt_q == '0) begin
            state_d = S_RUN;
            flush_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_FAULT: flush_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      redir_q <= 1'b0;
      cnt_q   <= '0;
      sp_q    <= '0;
      base_q  <= '0;
      fault_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      redir_q <= redir_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      base_q  <= base_d;
      fault_q <= fault_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage, written on every accepted call
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else if (push_en) begin
      stk_q[wr_idx] <= wr_data;
    end
  end

  assign pc        = pc_q;
  assign flush     = flush_q;
  assign redirect  = redir_q;
  assign sp        = sp_q;
  assign fault     = fault_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed and random stimulus against a queue-based model.
// Build with RAS_WRAP_EN defined to check the circular-stack variant.
module tb_branch_sequencer;

  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        instr_valid = 1'b0;
  logic [23:0] instruction = '0;
  logic        Z = 1'b0;
  logic        N = 1'b0;
  logic [7:0]  pc;
  logic        flush;
  logic        redirect;
  logic [2:0]  sp;
  logic        fault;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_sequencer #(
    .DEPTH(DEPTH),
    .FLUSH_CYCLES(FC),
    .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .Z(Z),
    .N(N),
    .pc(pc),
    .flush(flush),
    .redirect(redirect),
    .sp(sp),
    .fault(fault),
    .overflow(overflow),
    .underflow(underflow)
  );

  logic [7:0] m_pc;
  int         m_rem;
  bit         m_lock;
  bit         m_redir;
  bit         m_ovf;
  bit         m_unf;
  logic [7:0] m_stk[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [7:0] a, input logic [3:0] op,
                                     input logic c, input logic [7:0] t);
    return {a, op, c, 3'b000, t};
  endfunction

  task automatic model_reset();
    m_pc = 8'h00;
    m_rem = 0;
    m_lock = 0;
    m_redir = 0;
    m_ovf = 0;
    m_unf = 0;
    m_stk.delete();
  endtask

  task automatic model_edge(input logic st, input logic v,
                            input logic [23:0] ins, input logic z,
                            input logic n);
    bit take;
    logic [7:0] tgt;
    m_redir = 0;
    if (st || m_lock) return;
    if (m_rem > 0) begin
      m_pc = m_pc + 8'd2;
      m_rem--;
      return;
    end
    take = 0;
    tgt = ins[7:0];
    if (v) begin
      case (ins[15:12])
        4'h9: take = 1;
        4'hA: take = ins[11] ? n : z;
        4'hB: begin
          if (m_stk.size() == DEPTH) begin
            m_ovf = 1;
`ifdef RAS_WRAP_EN
            void'(m_stk.pop_front());
            m_stk.push_back(ins[23:16] + 8'd2);
            take = 1;
`else
            m_lock = 1;
`endif
          end else begin
            m_stk.push_back(ins[23:16] + 8'd2);
            take = 1;
          end
        end
        4'hC: begin
          if (m_stk.size() == 0) begin
            m_unf = 1;
            m_lock = 1;
          end else begin
            tgt = m_stk.pop_back();
            take = 1;
          end
        end
        default: ;
      endcase
    end
    if (m_lock) return;
    if (take) begin
      m_pc = tgt;
      m_redir = 1;
      m_rem = FC;
    end else begin
      m_pc = m_pc + 8'd2;
    end
  endtask

  task automatic compare(input string t);
    chk({t, ".pc"}, 32'(pc), 32'(m_pc));
    chk({t, ".flush"}, 32'(flush), 32'(m_lock || m_rem > 0));
    chk({t, ".redirect"}, 32'(redirect), 32'(m_redir));
    chk({t, ".sp"}, 32'(sp), 32'(m_stk.size()));
    chk({t, ".fault"}, 32'(fault), 32'(m_ovf && m_lock || m_unf));
    chk({t, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({t, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input logic st, input logic v, input logic [23:0] ins,
                      input logic z, input logic n);
    stall = st;
    instr_valid = v;
    instruction = ins;
    Z = z;
    N = n;
    @(posedge clk);
    model_edge(st, v, ins, z, n);
    @(negedge clk);
    compare("step");
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] op;
    int lockcnt;
    @(negedge clk);
    do_reset();

    idle(4);
    chk("seq_pc", 32'(pc), 32'h08);

    step(0, 1, mk(8'h10, 4'h9, 0, 8'h40), 0, 0);
    chk("br_pc", 32'(pc), 32'h40);
    chk("br_redir", 32'(redirect), 32'h1);
    step(0, 1, mk(8'h42, 4'h9, 0, 8'hEE), 0, 0);
    chk("br_fl1", 32'(flush), 32'h1);
    chk("br_pc42", 32'(pc), 32'h42);
    idle(1);
    chk("br_fl_end", 32'(flush), 32'h0);
    chk("br_pc44", 32'(pc), 32'h44);

    step(0, 1, mk(8'h44, 4'hA, 0, 8'h30), 0, 1);
    chk("brz_nt", 32'(pc), 32'h46);
    step(0, 1, mk(8'h46, 4'hA, 0, 8'h30), 1, 0);
    chk("brz_t", 32'(pc), 32'h30);
    idle(2);
    step(0, 1, mk(8'h34, 4'hA, 1, 8'h70), 0, 1);
    chk("brn_t", 32'(pc), 32'h70);
    idle(2);
    step(0, 1, mk(8'h74, 4'hA, 1, 8'h70), 1, 0);
    chk("brn_nt", 32'(pc), 32'h76);

    step(0, 1, mk(8'h20, 4'hB, 0, 8'h50), 0, 0);
    chk("call_sp", 32'(sp), 32'h1);
    idle(2);
    step(0, 1, mk(8'h54, 4'hC, 0, 8'h00), 0, 0);
    chk("ret_pc", 32'(pc), 32'h22);
    chk("ret_sp", 32'(sp), 32'h0);
    idle(2);

    step(0, 1, mk(8'h20, 4'hB, 0, 8'h60), 0, 0); idle(2);
    step(0, 1, mk(8'h60, 4'hB, 0, 8'hA0), 0, 0); idle(2);
    step(0, 1, mk(8'hA0, 4'hB, 0, 8'hC0), 0, 0); idle(2);
    chk("nest_sp", 32'(sp), 32'h3);
    step(0, 1, mk(8'hC4, 4'hC, 0, 8'h00), 0, 0);
    chk("nest_r1", 32'(pc), 32'hA2); idle(2);
    step(0, 1, mk(8'hA6, 4'hC, 0, 8'h00), 0, 0);
    chk("nest_r2", 32'(pc), 32'h62); idle(2);
    step(0, 1, mk(8'h66, 4'hC, 0, 8'h00), 0, 0);
    chk("nest_r3", 32'(pc), 32'h22); idle(2);

    step(0, 1, mk(8'h26, 4'hC, 0, 8'h00), 0, 0);
    chk("unf_pc", 32'(pc), 32'h26);
    chk("unf_flag", 32'(underflow), 32'h1);
    step(0, 1, mk(8'h26, 4'h9, 0, 8'h80), 0, 0);
    step(1, 1, mk(8'h26, 4'hB, 0, 8'h80), 0, 0);
    idle(2);
    chk("unf_hold", 32'(pc), 32'h26);
    chk("unf_flush", 32'(flush), 32'h1);
    do_reset();

    for (int i = 1; i <= 5; i++) begin
      step(0, 1, mk(8'(i * 16), 4'hB, 0, 8'(8'h80 + i * 16)), 0, 0);
      idle(2);
    end
`ifdef RAS_WRAP_EN
    chk("wrap_fault", 32'(fault), 32'h0);
    chk("wrap_ovf", 32'(overflow), 32'h1);
    for (int i = 5; i >= 2; i--) begin
      step(0, 1, mk(pc, 4'hC, 0, 8'h00), 0, 0);
      chk("wrap_ret", 32'(pc), 32'(i * 16 + 2));
      idle(2);
    end
`else
    chk("ovf_fault", 32'(fault), 32'h1);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_sp", 32'(sp), 32'h4);
`endif
    do_reset();

    step(0, 1, mk(8'h00, 4'h9, 0, 8'h40), 0, 0);
    step(1, 0, 24'h0, 0, 0);
    step(1, 1, mk(8'h00, 4'h9, 0, 8'h90), 0, 0);
    step(1, 0, 24'h0, 0, 0);
    chk("stl_pc", 32'(pc), 32'h40);
    chk("stl_flush", 32'(flush), 32'h1);
    chk("stl_redir", 32'(redirect), 32'h0);
    idle(1);
    chk("stl_pc42", 32'(pc), 32'h42);
    idle(1);
    chk("stl_done", 32'(flush), 32'h0);

    lockcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_lock) lockcnt++;
      if (lockcnt > 4) begin
        lockcnt = 0;
        do_reset();
      end
      case ($urandom_range(0, 7))
        0, 1: op = 4'h9;
        2, 3: op = 4'hA;
        4, 5: op = 4'hB;
        6: op = 4'hC;
        default: op = 4'($urandom);
      endcase
      step(($urandom % 8) == 0, ($urandom % 4) != 0,
           mk(m_pc, op, 1'($urandom), 8'($urandom)),
           1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
